// File: rtl/blk_mem_responder_if.sv
// Block request/refill/write-back bus between the cache controller (master)
// and the main-memory responder (slave).
interface blk_mem_responder_if #(
  parameter int ADD_SZ = 26,
  parameter int W      = 8
) ();
  logic              req_valid;
  logic              req_ready;
  logic              req_wr;
  logic [ADD_SZ-1:0] req_addr;
  logic              wdata_valid;
  logic              wdata_ready;
  logic [W-1:0]      wdata;
  logic              rdata_valid;
  logic              rdata_ready;
  logic [W-1:0]      rdata;
  logic              rdata_last;
  logic              wr_done;

  modport master (
    output req_valid, req_wr, req_addr, wdata_valid, wdata, rdata_ready,
    input  req_ready, wdata_ready, rdata_valid, rdata, rdata_last, wr_done
  );

  modport slave (
    input  req_valid, req_wr, req_addr, wdata_valid, wdata, rdata_ready,
    output req_ready, wdata_ready, rdata_valid, rdata, rdata_last, wr_done
  );
endinterface

// File: rtl/blk_mem_responder.sv
// Main-memory responder: serves one block refill (read) or write-back at a time
// from a word-addressed store and counts completed block reads and writes.
module blk_mem_responder #(
  parameter int ADD_SZ     = 26,
  parameter int W          = 8,
  parameter int B          = 64,
  parameter int BLK_OFF_SZ = 6,
  parameter int MEM_AW     = 12,
  parameter int MEM_LAT    = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  blk_mem_responder_if.slave   bus,
  output logic [31:0]          rd_count,
  output logic [31:0]          wr_count
);
  localparam int BASE_W = MEM_AW - BLK_OFF_SZ;
  localparam int DEPTH  = 1 << MEM_AW;
  localparam logic [BLK_OFF_SZ-1:0] BEAT_LAST = BLK_OFF_SZ'(B - 1);
  localparam logic [7:0] LAT_RD_LAST = 8'(MEM_LAT - 1);
  localparam logic [7:0] LAT_WR_LAST = 8'(MEM_LAT);

  typedef enum logic [2:0] {IDLE, RD_LAT, RD_BURST, WR_BURST, WR_LAT} state_t;

  state_t                state_q, state_d;
  logic [BLK_OFF_SZ-1:0] beat_q, beat_d;
  logic [7:0]            lat_q, lat_d;
  logic [BASE_W-1:0]     base_q, base_d;
  logic [31:0]           rd_cnt_q, rd_cnt_d;
  logic [31:0]           wr_cnt_q, wr_cnt_d;

  logic [W-1:0]          mem [0:DEPTH-1];
  logic [MEM_AW-1:0]     mem_idx;
  logic [W-1:0]          mem_rd;
  logic                  mem_we;

  logic req_ready, wdata_ready, rdata_valid, rdata_last, wr_done;

  // Words are stored XORed with their index so a zeroed power-up array reads as i mod 2^W.
  assign mem_idx = {base_q, beat_q};
  assign mem_rd  = mem[mem_idx] ^ W'(mem_idx);

  logic unused_addr_bits;
  assign unused_addr_bits = ^{bus.req_addr[ADD_SZ-1:MEM_AW], bus.req_addr[BLK_OFF_SZ-1:0]};

  always_comb begin
    state_d     = state_q;
    beat_d      = beat_q;
    lat_d       = lat_q;
    base_d      = base_q;
    rd_cnt_d    = rd_cnt_q;
    wr_cnt_d    = wr_cnt_q;
    req_ready   = 1'b0;
    wdata_ready = 1'b0;
    rdata_valid = 1'b0;
    rdata_last  = 1'b0;
    wr_done     = 1'b0;
    mem_we      = 1'b0;

    unique case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        if (bus.req_valid) begin
          base_d  = bus.req_addr[MEM_AW-1:BLK_OFF_SZ];
          beat_d  = '0;
          lat_d   = '0;
          state_d = bus.req_wr ? WR_BURST : RD_LAT;
        end
      end
      RD_LAT: begin
        if (lat_q == LAT_RD_LAST) begin
          lat_d   = '0;
          state_d = RD_BURST;
        end else begin
          lat_d = lat_q + 8'd1;
        end
      end
      RD_BURST: begin
        rdata_valid = 1'b1;
        rdata_last  = (beat_q == BEAT_LAST);
        if (bus.rdata_ready) begin
          if (beat_q == BEAT_LAST) begin
            rd_cnt_d = rd_cnt_q + 32'd1;
            state_d  = IDLE;
          end else begin
            beat_d = beat_q + 1'b1;
          end
        end
      end
      WR_BURST: begin
        wdata_ready = 1'b1;
        if (bus.wdata_valid) begin
          mem_we = 1'b1;
          if (beat_q == BEAT_LAST) begin
            lat_d   = '0;
            state_d = WR_LAT;
          end else begin
            beat_d = beat_q + 1'b1;
          end
        end
      end
      WR_LAT: begin
        // The final latency cycle carries the completion pulse.
        if (lat_q == LAT_WR_LAST) begin
          wr_done  = 1'b1;
          wr_cnt_d = wr_cnt_q + 32'd1;
          state_d  = IDLE;
        end else begin
          lat_d = lat_q + 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (!rst_n) begin
      req_ready   = 1'b0;
      wdata_ready = 1'b0;
      rdata_valid = 1'b0;
      rdata_last  = 1'b0;
      wr_done     = 1'b0;
      mem_we      = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      beat_q   <= '0;
      lat_q    <= '0;
      rd_cnt_q <= '0;
      wr_cnt_q <= '0;
    end else begin
      state_q  <= state_d;
      beat_q   <= beat_d;
      lat_q    <= lat_d;
      rd_cnt_q <= rd_cnt_d;
      wr_cnt_q <= wr_cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    base_q <= base_d;
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[mem_idx] <= bus.wdata ^ W'(mem_idx);
    end
  end

  assign bus.req_ready   = req_ready;
  assign bus.wdata_ready = wdata_ready;
  assign bus.rdata_valid = rdata_valid;
  assign bus.rdata_last  = rdata_last;
  assign bus.rdata       = rdata_valid ? mem_rd : '0;
  assign bus.wr_done     = wr_done;
  assign rd_count        = rd_cnt_q;
  assign wr_count        = wr_cnt_q;
endmodule

// File: tb/tb_blk_mem_responder.sv
// Randomized bench for blk_mem_responder against a flat-array memory model.
module tb_blk_mem_responder;
  localparam int ADD_SZ = 26, W = 8, B = 64, BLK_OFF_SZ = 6, MEM_AW = 12, MEM_LAT = 4;
  localparam int DEPTH = 1 << MEM_AW;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [31:0] rd_count, wr_count;

  blk_mem_responder_if #(.ADD_SZ(ADD_SZ), .W(W)) bus ();

  blk_mem_responder #(
    .ADD_SZ(ADD_SZ), .W(W), .B(B), .BLK_OFF_SZ(BLK_OFF_SZ), .MEM_AW(MEM_AW), .MEM_LAT(MEM_LAT)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus), .rd_count(rd_count), .wr_count(wr_count)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [W-1:0] ref_mem [DEPTH];
  int unsigned  exp_rd = 0, exp_wr = 0;
  int pass_cnt = 0, total_cnt = 0;

  logic [W-1:0] got_data [B];
  logic         got_last [B];
  logic [W-1:0] wr_data  [B];
  logic [W-1:0] saved    [B];
  int  got_n, first_lat, last_rel, stall_err, accept_during;
  int  wrdy_first, done_pulses, done_rel, rr_rel;
  logic rr_after;
  bit  timeout;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int base_of(input logic [ADD_SZ-1:0] a);
    return (int'(a % DEPTH) / B) * B;
  endfunction

  function automatic int data_errs(input int base);
    int e = 0;
    for (int k = 0; k < B; k++)
      if (got_data[k] !== ref_mem[base + k] || got_last[k] !== (k == B - 1)) e++;
    return e;
  endfunction

  task automatic wait_ready(output bit to);
    to = 0;
    for (int i = 0; i < 1000 && bus.req_ready !== 1'b1; i++) tick();
    if (bus.req_ready !== 1'b1) to = 1;
  endtask

  task automatic run_read(input logic [ADD_SZ-1:0] addr, input bit toggle, input bit hold);
    int t_acc;
    bit phase, xfer, have_prev, to;
    logic [W-1:0] prev;
    got_n = 0; first_lat = -1; last_rel = -1; stall_err = 0; accept_during = 0; timeout = 0;
    prev = '0;
    wait_ready(to);
    if (to) begin timeout = 1; return; end
    bus.req_valid = 1; bus.req_wr = 0; bus.req_addr = addr;
    tick();
    t_acc = cyc;
    if (!hold) bus.req_valid = 0;
    phase = 1; have_prev = 0;
    for (int i = 0; i < 2000 && got_n < B; i++) begin
      if (bus.req_ready === 1'b1) accept_during++;
      xfer = 0;
      if (bus.rdata_valid === 1'b1) begin
        if (first_lat < 0) first_lat = cyc - t_acc;
        if (have_prev && bus.rdata !== prev) stall_err++;
        bus.rdata_ready = toggle ? phase : 1'b1;
        phase = ~phase;
        if (bus.rdata_ready) begin
          got_data[got_n] = bus.rdata; got_last[got_n] = bus.rdata_last;
          got_n++; xfer = 1; have_prev = 0;
        end else begin
          prev = bus.rdata; have_prev = 1;
        end
      end else begin
        bus.rdata_ready = 0;
      end
      tick();
      if (xfer && got_n == B) last_rel = cyc - t_acc;
    end
    bus.rdata_ready = 0;
    if (got_n < B) timeout = 1;
    rr_after = bus.req_ready;
    if (hold) bus.req_valid = 0;
  endtask

  task automatic run_write(input logic [ADD_SZ-1:0] addr, input bit stall, input int abort_at);
    int n, last_e;
    bit xfer, to;
    timeout = 0; wrdy_first = 0; done_pulses = 0; done_rel = -1; rr_rel = -1;
    wait_ready(to);
    if (to) begin timeout = 1; return; end
    bus.req_valid = 1; bus.req_wr = 1; bus.req_addr = addr; bus.wdata_valid = 0;
    tick();
    bus.req_valid = 0;
    wrdy_first = int'(bus.wdata_ready === 1'b1);
    n = 0; last_e = -1;
    for (int i = 0; i < 4000 && n < B; i++) begin
      if (n == abort_at) begin
        bus.wdata_valid = 1; bus.wdata = wr_data[n]; rst_n = 0;
        tick();
        bus.wdata_valid = 0;
        return;
      end
      xfer = 0;
      if (bus.wdata_ready === 1'b1) begin
        bus.wdata_valid = stall ? ($urandom % 3 != 0) : 1'b1;
        bus.wdata = bus.wdata_valid ? wr_data[n] : W'($urandom);
        xfer = bus.wdata_valid;
      end else begin
        bus.wdata_valid = 0;
      end
      tick();
      if (xfer) begin n++; if (n == B) last_e = cyc; end
    end
    bus.wdata_valid = 0;
    if (n < B) begin timeout = 1; return; end
    for (int i = 0; i < 300; i++) begin
      if (bus.wr_done === 1'b1) begin
        done_pulses++;
        if (done_rel < 0) done_rel = cyc - last_e;
      end
      if (bus.req_ready === 1'b1) begin rr_rel = cyc - last_e; break; end
      tick();
    end
  endtask

  task automatic test_reset();
    rst_n = 0;
    tick(); tick(); tick();
    total_cnt++;
    if ({bus.req_ready, bus.wdata_ready, bus.rdata_valid, bus.rdata_last, bus.wr_done} !== 5'b0)
      $display("FAIL reset_ctrl_outs got %b want 00000",
               {bus.req_ready, bus.wdata_ready, bus.rdata_valid, bus.rdata_last, bus.wr_done});
    else pass_cnt++;
    total_cnt++;
    if (bus.rdata !== '0) $display("FAIL reset_rdata got %h want 00", bus.rdata); else pass_cnt++;
    total_cnt++;
    if (rd_count !== 0 || wr_count !== 0)
      $display("FAIL reset_counts got rd=%0d wr=%0d want 0/0", rd_count, wr_count);
    else pass_cnt++;
    rst_n = 1;
    #1;
    total_cnt++;
    if (bus.req_ready !== 1'b1) $display("FAIL reset_release_ready got %b want 1", bus.req_ready);
    else pass_cnt++;
  endtask

  task automatic test_read_basic();
    int e;
    run_read(26'h40, 0, 0);
    exp_rd++;
    total_cnt++;
    if (timeout) $display("FAIL rd_basic_timeout got %0d beats want %0d", got_n, B); else pass_cnt++;
    total_cnt++;
    if (first_lat !== MEM_LAT) $display("FAIL rd_basic_latency got %0d want %0d", first_lat, MEM_LAT);
    else pass_cnt++;
    e = data_errs(base_of(26'h40));
    total_cnt++;
    if (e !== 0) $display("FAIL rd_basic_data got %0d bad beats (beat0=%h last=%h) want 0", e, got_data[0], got_data[B-1]);
    else pass_cnt++;
    total_cnt++;
    if (last_rel !== MEM_LAT + B) $display("FAIL rd_basic_last_edge got T+%0d want T+%0d", last_rel, MEM_LAT + B);
    else pass_cnt++;
    total_cnt++;
    if (rr_after !== 1'b1) $display("FAIL rd_basic_ready_after got %b want 1", rr_after); else pass_cnt++;
    total_cnt++;
    if (rd_count !== exp_rd) $display("FAIL rd_basic_count got %0d want %0d", rd_count, exp_rd); else pass_cnt++;
  endtask

  task automatic test_write_basic();
    int e;
    for (int k = 0; k < B; k++) wr_data[k] = W'(8'hFF - k);
    run_write(26'h80, 0, -1);
    for (int k = 0; k < B; k++) ref_mem[base_of(26'h80) + k] = wr_data[k];
    exp_wr++;
    total_cnt++;
    if (timeout) $display("FAIL wr_basic_timeout got timeout want completion"); else pass_cnt++;
    total_cnt++;
    if (wrdy_first !== 1) $display("FAIL wr_basic_wdata_ready got %0d want 1", wrdy_first); else pass_cnt++;
    total_cnt++;
    if (done_pulses !== 1 || done_rel !== MEM_LAT)
      $display("FAIL wr_basic_done got pulses=%0d at E+%0d want 1 at E+%0d", done_pulses, done_rel, MEM_LAT);
    else pass_cnt++;
    total_cnt++;
    if (rr_rel !== MEM_LAT + 1) $display("FAIL wr_basic_ready_after got E+%0d want E+%0d", rr_rel, MEM_LAT + 1);
    else pass_cnt++;
    total_cnt++;
    if (wr_count !== exp_wr) $display("FAIL wr_basic_count got %0d want %0d", wr_count, exp_wr); else pass_cnt++;
    run_read(26'h80, 0, 0);
    exp_rd++;
    e = data_errs(base_of(26'h80));
    total_cnt++;
    if (e !== 0 || got_data[0] !== 8'hFF || got_data[B-1] !== 8'hC0)
      $display("FAIL wr_readback got %0d bad, first=%h last=%h want 0 bad, FF..C0", e, got_data[0], got_data[B-1]);
    else pass_cnt++;
  endtask

  task automatic test_stall_read();
    int e;
    run_read(26'h40, 1, 0);
    exp_rd++;
    total_cnt++;
    if (stall_err !== 0) $display("FAIL stall_hold got %0d changes want 0", stall_err); else pass_cnt++;
    e = data_errs(base_of(26'h40));
    total_cnt++;
    if (e !== 0) $display("FAIL stall_data got %0d bad beats want 0", e); else pass_cnt++;
    total_cnt++;
    if (last_rel !== MEM_LAT + 2 * B - 1)
      $display("FAIL stall_last_edge got T+%0d want T+%0d", last_rel, MEM_LAT + 2 * B - 1);
    else pass_cnt++;
    total_cnt++;
    if (rd_count !== exp_rd) $display("FAIL stall_count got %0d want %0d", rd_count, exp_rd); else pass_cnt++;
  endtask

  task automatic test_alias();
    int d;
    run_read(26'h0000, 0, 0);
    exp_rd++;
    for (int k = 0; k < B; k++) saved[k] = got_data[k];
    run_read(26'h1000, 0, 0);
    exp_rd++;
    d = 0;
    for (int k = 0; k < B; k++) if (got_data[k] !== saved[k]) d++;
    total_cnt++;
    if (d !== 0) $display("FAIL alias_match got %0d differing beats want 0", d); else pass_cnt++;
    d = data_errs(0);
    total_cnt++;
    if (d !== 0) $display("FAIL alias_data got %0d bad beats want 0", d); else pass_cnt++;
  endtask

  task automatic test_req_held();
    int e;
    run_read(26'h100, 0, 1);
    exp_rd++;
    total_cnt++;
    if (accept_during !== 0) $display("FAIL held_no_accept got %0d ready cycles want 0", accept_during);
    else pass_cnt++;
    e = data_errs(base_of(26'h100));
    total_cnt++;
    if (e !== 0) $display("FAIL held_data got %0d bad beats want 0", e); else pass_cnt++;
    total_cnt++;
    if (rd_count !== exp_rd) $display("FAIL held_count got %0d want %0d", rd_count, exp_rd); else pass_cnt++;
  endtask

  task automatic test_random_mix();
    logic [ADD_SZ-1:0] a;
    int e;
    for (int it = 0; it < 8; it++) begin
      a = ADD_SZ'($urandom);
      if ($urandom % 2 == 0) begin
        for (int k = 0; k < B; k++) wr_data[k] = W'($urandom);
        run_write(a, 1, -1);
        for (int k = 0; k < B; k++) ref_mem[base_of(a) + k] = wr_data[k];
        exp_wr++;
        total_cnt++;
        if (timeout || done_pulses !== 1 || done_rel !== MEM_LAT)
          $display("FAIL rand_wr_done addr=%h got to=%0d pulses=%0d rel=%0d want 0/1/%0d",
                   a, timeout, done_pulses, done_rel, MEM_LAT);
        else pass_cnt++;
        total_cnt++;
        if (wr_count !== exp_wr) $display("FAIL rand_wr_count got %0d want %0d", wr_count, exp_wr);
        else pass_cnt++;
      end
      run_read(a, ($urandom % 2) == 1, 0);
      exp_rd++;
      e = data_errs(base_of(a));
      total_cnt++;
      if (timeout || e !== 0 || stall_err !== 0)
        $display("FAIL rand_rd addr=%h got to=%0d bad=%0d stall=%0d want 0/0/0", a, timeout, e, stall_err);
      else pass_cnt++;
      total_cnt++;
      if (rd_count !== exp_rd) $display("FAIL rand_rd_count got %0d want %0d", rd_count, exp_rd);
      else pass_cnt++;
    end
  endtask

  task automatic test_reset_mid_write();
    int e;
    for (int k = 0; k < B; k++) wr_data[k] = W'($urandom);
    run_write(26'h80, 0, 20);
    total_cnt++;
    if ({bus.req_ready, bus.wdata_ready, bus.rdata_valid, bus.rdata_last, bus.wr_done, bus.rdata} !== '0)
      $display("FAIL abort_outs_zero got %b/%h want 0/00",
               {bus.req_ready, bus.wdata_ready, bus.rdata_valid, bus.rdata_last, bus.wr_done}, bus.rdata);
    else pass_cnt++;
    rst_n = 1;
    #1;
    for (int k = 0; k < 20; k++) ref_mem[base_of(26'h80) + k] = wr_data[k];
    exp_rd = 0; exp_wr = 0;
    total_cnt++;
    if (bus.req_ready !== 1'b1) $display("FAIL abort_ready got %b want 1", bus.req_ready); else pass_cnt++;
    total_cnt++;
    if (wr_count !== exp_wr || rd_count !== exp_rd)
      $display("FAIL abort_counts got wr=%0d rd=%0d want %0d/%0d", wr_count, rd_count, exp_wr, exp_rd);
    else pass_cnt++;
    run_read(26'h80, 0, 0);
    exp_rd++;
    e = data_errs(base_of(26'h80));
    total_cnt++;
    if (e !== 0) $display("FAIL abort_mem got %0d bad beats (w19=%h w20=%h) want 0", e, got_data[19], got_data[20]);
    else pass_cnt++;
    total_cnt++;
    if (rd_count !== exp_rd) $display("FAIL abort_rd_count got %0d want %0d", rd_count, exp_rd); else pass_cnt++;
  endtask

  initial begin
    bus.req_valid = 0; bus.req_wr = 0; bus.req_addr = '0;
    bus.wdata_valid = 0; bus.wdata = '0; bus.rdata_ready = 0;
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = W'(i);
    test_reset();
    test_read_basic();
    test_write_basic();
    test_stall_read();
    test_alias();
    test_req_held();
    test_random_mix();
    test_reset_mid_write();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule

// File: doc/blk_mem_responder.md
# blk_mem_responder

Main-memory responder at the lower end of the cache's refill and write-back path. It accepts one block request at a time from the cache controller. On a read it returns a B-word block after a fixed latency. On a write-back it absorbs a B-word block and acknowledges completion. The word-addressed store is sized by parameter, and it counts completed block reads and writes for hit/miss statistics.

## Interface
- ADD_SZ, 26, word address width (matches cache address field)
- W, 8, bits per word
- B, 64, words per block
- BLK_OFF_SZ, 6, log2(B)
- MEM_AW, 12, implemented store depth 2^MEM_AW words; address taken modulo 2^MEM_AW
- MEM_LAT, 4, access latency in cycles, legal range 1..255

Ports:
- clk  in  1  single clock, all logic on posedge
- rst_n  in  1  synchronous, active-low reset
- req_valid  in  1  block request present
- req_ready  out  1  responder can accept a request
- req_wr  in  1  1 = write-back, 0 = refill read
- req_addr  in  ADD_SZ  block address; low BLK_OFF_SZ bits ignored
- wdata_valid  in  1  write-back word present
- wdata_ready  out  1  responder accepts write word
- wdata  in  W  write-back word
- rdata_valid  out  1  refill word present
- rdata_ready  in  1  cache accepts refill word
- rdata  out  W  refill word
- rdata_last  out  1  marks beat B-1 of the refill
- wr_done  out  1  one-cycle pulse, write-back committed
- rd_count  out  32  completed block reads
- wr_count  out  32  completed block writes

## Operation
- The FSM has five states: IDLE, RD_LAT, RD_BURST, WR_BURST, WR_LAT.
- IDLE:
  - req_ready=1.
  - On req_valid&req_ready, capture base = req_addr[MEM_AW-1:BLK_OFF_SZ] and clear beat counter.
  - Go to RD_LAT if req_wr=0, otherwise WR_BURST.
- RD_LAT:
  - Count MEM_LAT-1 cycles, then go to RD_BURST.
  - With MEM_LAT=1, go to RD_BURST after one cycle in RD_LAT.
- RD_BURST:
  - rdata_valid=1 and rdata = mem[{base,beat}].
  - Beat advances only on rdata_valid&rdata_ready.
  - rdata and rdata_last stay stable while stalled.
  - rdata_last=1 exactly when beat==B-1.
  - On the last transfer: rd_count+1 and go to IDLE.
- WR_BURST:
  - wdata_ready=1.
  - On wdata_valid&wdata_ready, write mem[{base,beat}]=wdata and advance beat.
  - After beat B-1 is written, go to WR_LAT.
- WR_LAT:
  - Wait MEM_LAT cycles.
  - Assert wr_done for one cycle, wr_count+1, and go to IDLE in the same edge.
- Beat counter is BLK_OFF_SZ bits wide; it never wraps within a burst.
- Counters wrap modulo 2^32.
- Requests arriving in any state other than IDLE are not accepted; req_ready=0 there.
- Memory array:
  - Unaffected by reset.
  - Simulation power-up content is mem[i] = i mod 2^W.
  - Upper address bits above MEM_AW are ignored (aliasing).

## Timing
- Reset (rst_n=0 at posedge): state=IDLE, beat=0, latency counter=0, rd_count=0, wr_count=0.
- All outputs during reset: req_ready=0, wdata_ready=0, rdata_valid=0, rdata_last=0, wr_done=0, rdata=0.
- req_ready rises in the first cycle after rst_n returns high.
- Reset mid-burst abandons the transaction:
  - No count increment and no wr_done.
  - Words already written stay written.
- Read latency: request accepted at edge T, first rdata_valid seen in the cycle after edge T+MEM_LAT. With no stalls, the last beat transfers at edge T+MEM_LAT+B.
- req_ready returns high in the cycle after the last read transfer. There is no back-to-back accept on the same edge as the last beat.
- Write: wdata_ready high in the cycle after the accept edge.
- After the final write beat at edge E, wr_done is high in the cycle after edge E+MEM_LAT. req_ready is high the following cycle.
- wdata_valid=0 stalls the write burst indefinitely with no timeout.
- rdata_ready=0 stalls the read burst indefinitely.

## Test plan
- Reset then read at req_addr=0x40:
  - rdata_valid first seen 4 cycles after accept (MEM_LAT=4).
  - Beats carry 0x40..0x7F.
  - rdata_last on the beat with 0x7F.
  - rd_count=1.
- Write-back at req_addr=0x80 with wdata=0xFF-beat:
  - wr_done pulses exactly once, 4 cycles after the final beat.
  - wr_count=1.
  - A following read of 0x80 returns 0xFF..0xC0.
- Read at 0x40 with rdata_ready toggling every other cycle:
  - rdata is held stable during stalls.
  - All 64 words are returned in order.
  - The last transfer occurs at edge T+4+127.
- Aliasing: read req_addr=0x1000 (MEM_AW=12) returns the same data as req_addr=0x0000.
- Assert rst_n=0 at beat 20 of a write-back:
  - All outputs zero next cycle.
  - wr_count unchanged.
  - Words 0..19 of that block updated, words 20..63 keep their old value.
- req_valid held high during a read burst: no second accept until IDLE, and rd_count increments once per block.
